// File: rtl/hp_manager.sv
// ============================================================================
// hp_manager : hit-point bookkeeping and win/lose verdict for the battle game.
// Optional HP_COMBO_EN: doubled damage from the third consecutive GOOD entry.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module hp_manager #(
   parameter int HP_MAX = 5,
   parameter int HP_W   = 3,
   parameter int DMG    = 1
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [3:0]      STATE,
   output logic [1:0]      HP_OUT,
   output logic [HP_W-1:0] HP_SELF,
   output logic [HP_W-1:0] HP_OPP,
   output logic            HIT
);

   // Two spare bits so that 2*DMG and the comparisons never overflow.
   localparam int CW = HP_W + 2;

   localparam logic [3:0] ST_READY = 4'b0010;
   localparam logic [3:0] ST_DRAW  = 4'b0110;
   localparam logic [3:0] ST_GOOD  = 4'b1000;
   localparam logic [3:0] ST_OUCH  = 4'b1001;
   localparam logic [3:0] ST_WIN   = 4'b1010;
   localparam logic [3:0] ST_LOSE  = 4'b1011;

   localparam logic [1:0] V_NONE = 2'b00;
   localparam logic [1:0] V_WIN  = 2'b01;
   localparam logic [1:0] V_LOSE = 2'b10;

   localparam logic [HP_W-1:0] C_HP_MAX = HP_W'(HP_MAX);
   localparam logic [CW-1:0]   C_DMG    = CW'(DMG);
`ifdef HP_COMBO_EN
   localparam logic [CW-1:0]   C_DMG2   = CW'(2 * DMG);
`endif

   logic [3:0]      prev;
   logic [HP_W-1:0] hp_self;
   logic [HP_W-1:0] hp_opp;
   logic [1:0]      verdict;
   logic            hit;

   logic [HP_W-1:0] self_nxt;
   logic [HP_W-1:0] opp_nxt;
   logic [1:0]      verdict_nxt;
   logic            hit_nxt;
   logic            entry;
   logic            refill;
   logic [CW-1:0]   dmg_good;

`ifdef HP_COMBO_EN
   logic [1:0]      streak;
   logic [1:0]      streak_nxt;
`endif

   function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                               input logic [CW-1:0]   d);
      logic [CW-1:0] ext;
      ext = CW'(hp);
      if (ext <= d) return '0;
      return HP_W'(ext - d);
   endfunction

   // Draw damage never knocks a player out; a dead value (unreachable) stays put.
   function automatic logic [HP_W-1:0] floor_sub(input logic [HP_W-1:0] hp,
                                                 input logic [CW-1:0]   d);
      logic [CW-1:0] ext;
      ext = CW'(hp);
      if (hp == '0) return '0;
      if (ext > d)  return HP_W'(ext - d);
      return HP_W'(1);
   endfunction

   always_comb begin
      entry  = (STATE != prev) &&
               ((STATE == ST_GOOD) || (STATE == ST_OUCH) || (STATE == ST_DRAW));
      refill = ((prev == ST_WIN) || (prev == ST_LOSE)) && (STATE == ST_READY);
`ifdef HP_COMBO_EN
      dmg_good = (streak >= 2'd2) ? C_DMG2 : C_DMG;
`else
      dmg_good = C_DMG;
`endif
   end

   always_comb begin
      self_nxt    = hp_self;
      opp_nxt     = hp_opp;
      verdict_nxt = verdict;
      hit_nxt     = 1'b0;
`ifdef HP_COMBO_EN
      streak_nxt  = streak;
`endif
      if (refill) begin
         self_nxt    = C_HP_MAX;
         opp_nxt     = C_HP_MAX;
         verdict_nxt = V_NONE;
`ifdef HP_COMBO_EN
         streak_nxt  = 2'd0;
`endif
      end else if (entry && (verdict == V_NONE)) begin
         case (STATE)
            ST_GOOD: begin
               opp_nxt = sat_sub(hp_opp, dmg_good);
               if (opp_nxt == '0) verdict_nxt = V_WIN;
`ifdef HP_COMBO_EN
               if (streak != 2'd3) streak_nxt = streak + 2'd1;
`endif
            end
            ST_OUCH: begin
               self_nxt = sat_sub(hp_self, C_DMG);
               if (self_nxt == '0) verdict_nxt = V_LOSE;
`ifdef HP_COMBO_EN
               streak_nxt = 2'd0;
`endif
            end
            default: begin
               self_nxt = floor_sub(hp_self, C_DMG);
               opp_nxt  = floor_sub(hp_opp, C_DMG);
`ifdef HP_COMBO_EN
               streak_nxt = 2'd0;
`endif
            end
         endcase
         hit_nxt = (self_nxt != hp_self) || (opp_nxt != hp_opp);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         prev    <= ST_READY;
         hp_self <= C_HP_MAX;
         hp_opp  <= C_HP_MAX;
         verdict <= V_NONE;
         hit     <= 1'b0;
`ifdef HP_COMBO_EN
         streak  <= 2'd0;
`endif
      end else begin
         prev    <= STATE;
         hp_self <= self_nxt;
         hp_opp  <= opp_nxt;
         verdict <= verdict_nxt;
         hit     <= hit_nxt;
`ifdef HP_COMBO_EN
         streak  <= streak_nxt;
`endif
      end
   end

   assign HP_OUT  = verdict;
   assign HP_SELF = hp_self;
   assign HP_OPP  = hp_opp;
   assign HIT     = hit;

endmodule

`default_nettype wire

// File: tb/tb_hp_manager.sv
// Self-checking bench for hp_manager: directed scenarios plus randomized
// STATE sequences compared against a rule-level reference model.
`default_nettype none

module tb_hp_manager;

   localparam int HP_MAX = 5;
   localparam int HP_W   = 3;
   localparam int DMG    = 1;

   localparam logic [3:0] READY    = 4'b0010;
   localparam logic [3:0] QUESTION = 4'b0011;
   localparam logic [3:0] INPUT    = 4'b0100;
   localparam logic [3:0] DRAW     = 4'b0110;
   localparam logic [3:0] WRONG    = 4'b0111;
   localparam logic [3:0] GOOD     = 4'b1000;
   localparam logic [3:0] OUCH     = 4'b1001;
   localparam logic [3:0] WIN      = 4'b1010;
   localparam logic [3:0] LOSE     = 4'b1011;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [3:0]      state = READY;
   logic [1:0]      hp_out;
   logic [HP_W-1:0] hp_self;
   logic [HP_W-1:0] hp_opp;
   logic            hit;

   int passed = 0;
   int total  = 0;

   // Reference model state
   int         m_self, m_opp, m_verdict, m_good_run;
   logic [3:0] m_prev;
   bit         m_hit;

   always #5 clk = ~clk;

   hp_manager #(.HP_MAX(HP_MAX), .HP_W(HP_W), .DMG(DMG)) dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .STATE   (state),
      .HP_OUT  (hp_out),
      .HP_SELF (hp_self),
      .HP_OPP  (hp_opp),
      .HIT     (hit)
   );

   task automatic model_reset();
      m_self = HP_MAX; m_opp = HP_MAX; m_verdict = 0;
      m_good_run = 0; m_prev = READY; m_hit = 0;
   endtask

   task automatic model_step(input logic [3:0] s);
      int d, old_s, old_o;
      m_hit = 0;
      if ((m_prev == WIN || m_prev == LOSE) && s == READY) begin
         m_self = HP_MAX; m_opp = HP_MAX; m_verdict = 0; m_good_run = 0;
      end else if (s != m_prev && m_verdict == 0 &&
                   (s == GOOD || s == OUCH || s == DRAW)) begin
         old_s = m_self; old_o = m_opp;
         if (s == GOOD) begin
            d = DMG;
`ifdef HP_COMBO_EN
            if (m_good_run >= 2) d = 2 * DMG;
`endif
            m_good_run++;
            m_opp = (m_opp > d) ? m_opp - d : 0;
            if (m_opp == 0) m_verdict = 1;
         end else if (s == OUCH) begin
            m_good_run = 0;
            m_self = (m_self > DMG) ? m_self - DMG : 0;
            if (m_self == 0) m_verdict = 2;
         end else begin
            m_good_run = 0;
            m_self = (m_self - DMG < 1) ? 1 : m_self - DMG;
            m_opp  = (m_opp - DMG < 1) ? 1 : m_opp - DMG;
         end
         m_hit = (old_s != m_self) || (old_o != m_opp);
      end
      m_prev = s;
   endtask

   // Present s to the DUT for one clock, then sample 1 time unit after the edge.
   task automatic cycle(input logic [3:0] s);
      state = s;
      @(posedge clk);
      #1;
      model_step(s);
   endtask

   task automatic apply_reset();
      state = READY;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (hp_self !== 3'd5) $display("FAIL reset_self got=%0d exp=5", hp_self); else passed++;
      total++; if (hp_opp !== 3'd5) $display("FAIL reset_opp got=%0d exp=5", hp_opp); else passed++;
      total++; if (hp_out !== 2'b00) $display("FAIL reset_out got=%b exp=00", hp_out); else passed++;
      total++; if (hit !== 1'b0) $display("FAIL reset_hit got=%b exp=0", hit); else passed++;
   endtask

   task automatic test_hold_good();
      int hits;
      apply_reset();
      cycle(GOOD);
      total++; if (hp_opp !== 3'd4 || hit !== 1'b1)
         $display("FAIL hold_first opp=%0d hit=%b exp opp=4 hit=1", hp_opp, hit); else passed++;
      hits = 0;
      for (int i = 0; i < 7; i++) begin
         cycle(GOOD);
         if (hit) hits++;
      end
      total++; if (hits != 0 || hp_opp !== 3'd4 || hp_out !== 2'b00)
         $display("FAIL hold_repeat hits=%0d opp=%0d out=%b exp hits=0 opp=4 out=00", hits, hp_opp, hp_out);
      else passed++;
   endtask

   task automatic test_good_to_win();
      apply_reset();
      for (int i = 1; i <= 5; i++) begin
         cycle(GOOD);
`ifdef HP_COMBO_EN
         cycle(OUCH);   // keeps the streak from growing so damage stays at DMG
         cycle(READY);
         if (i == 5) cycle(GOOD);
`endif
         cycle(READY);
      end
`ifndef HP_COMBO_EN
      total++; if (hp_opp !== 3'd0 || hp_out !== 2'b01)
         $display("FAIL win_reach opp=%0d out=%b exp opp=0 out=01", hp_opp, hp_out); else passed++;
`endif
      cycle(GOOD);
      total++; if (hit !== 1'b0 || hp_out !== 2'b01 || hp_opp !== 3'd0)
         $display("FAIL win_ignore hit=%b out=%b opp=%0d exp hit=0 out=01 opp=0", hit, hp_out, hp_opp);
      else passed++;
   endtask

   task automatic test_ouch_lose_refill();
      apply_reset();
      for (int i = 1; i <= 5; i++) begin
         cycle(OUCH);
         total++; if (hp_self !== HP_W'(5 - i) || hit !== 1'b1 || hp_out !== ((i == 5) ? 2'b10 : 2'b00))
            $display("FAIL ouch_step%0d self=%0d hit=%b out=%b exp self=%0d hit=1", i, hp_self, hit, hp_out, 5 - i);
         else passed++;
         cycle(READY); cycle(QUESTION); cycle(INPUT);
      end
      cycle(LOSE);
      total++; if (hp_out !== 2'b10) $display("FAIL lose_hold got=%b exp=10", hp_out); else passed++;
      cycle(READY);
      total++; if (hp_self !== 3'd5 || hp_opp !== 3'd5 || hp_out !== 2'b00)
         $display("FAIL refill self=%0d opp=%0d out=%b exp 5 5 00", hp_self, hp_opp, hp_out); else passed++;
   endtask

   task automatic test_draw_floor();
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(GOOD); cycle(READY); cycle(OUCH); cycle(READY);
      end
      cycle(DRAW);
      total++; if (hp_self !== 3'd2 || hp_opp !== 3'd2 || hit !== 1'b1)
         $display("FAIL draw_dec self=%0d opp=%0d hit=%b exp 2 2 1", hp_self, hp_opp, hit); else passed++;
      cycle(READY);
      cycle(GOOD); cycle(READY); cycle(OUCH); cycle(READY);
      cycle(DRAW);
      total++; if (hp_self !== 3'd1 || hp_opp !== 3'd1 || hit !== 1'b0 || hp_out !== 2'b00)
         $display("FAIL draw_floor self=%0d opp=%0d hit=%b out=%b exp 1 1 0 00", hp_self, hp_opp, hit, hp_out);
      else passed++;
   endtask

   task automatic test_async_reset();
      apply_reset();
      cycle(OUCH); cycle(READY); cycle(OUCH); cycle(READY); cycle(OUCH);
      total++; if (hp_self !== 3'd2 || hit !== 1'b1)
         $display("FAIL areset_pre self=%0d hit=%b exp 2 1", hp_self, hit); else passed++;
      #2;
      state = READY;
      rst_n = 1'b0;
      #1;
      total++; if (hp_self !== 3'd5 || hp_out !== 2'b00 || hit !== 1'b0 || hp_opp !== 3'd5)
         $display("FAIL areset_now self=%0d opp=%0d out=%b hit=%b exp 5 5 00 0", hp_self, hp_opp, hp_out, hit);
      else passed++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_combo();
      apply_reset();
      cycle(GOOD); cycle(READY);
      cycle(GOOD);
      total++; if (hp_opp !== 3'd3) $display("FAIL combo_second got=%0d exp=3", hp_opp); else passed++;
      cycle(READY);
      cycle(GOOD);
`ifdef HP_COMBO_EN
      total++; if (hp_opp !== 3'd1) $display("FAIL combo_third got=%0d exp=1", hp_opp); else passed++;
`else
      total++; if (hp_opp !== 3'd2) $display("FAIL combo_third got=%0d exp=2", hp_opp); else passed++;
`endif
   endtask

   task automatic test_random();
      logic [3:0] codes [10];
      logic [3:0] s;
      codes = '{READY, QUESTION, INPUT, DRAW, WRONG, GOOD, OUCH, WIN, LOSE, 4'b1111};
      apply_reset();
      s = READY;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) != 0) s = codes[$urandom_range(0, 9)];
         cycle(s);
         total++;
         if (hp_self !== HP_W'(m_self) || hp_opp !== HP_W'(m_opp) ||
             hp_out !== 2'(m_verdict) || hit !== m_hit)
            $display("FAIL rand cyc=%0d st=%b self=%0d/%0d opp=%0d/%0d out=%b/%0d hit=%b/%0d",
                     c, s, hp_self, m_self, hp_opp, m_opp, hp_out, m_verdict, hit, m_hit);
         else passed++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      model_reset();
      test_reset();
      test_hold_good();
      test_good_to_win();
      test_ouch_lose_refill();
      test_draw_floor();
      test_async_reset();
      test_combo();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
